// File: rtl/alu_pkg.sv
// Shared constants for the 8-bit registered ALU: datapath width and opcode encodings.
package alu_pkg;

   localparam int unsigned ALU_W = 8;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_SHL  = 3'd2;
   localparam logic [2:0] OP_SHR  = 3'd3;
   localparam logic [2:0] OP_NEG  = 3'd4;
   localparam logic [2:0] OP_DIV  = 3'd5;
   localparam logic [2:0] OP_MOD  = 3'd6;
   localparam logic [2:0] OP_PASS = 3'd7;

endpackage

// File: rtl/alu_divider.sv
// Combinational unsigned restoring divider, one stage per dividend bit (MSB first).
// A zero divisor naturally yields quotient 0xFF and remainder equal to the dividend.
module alu_divider
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] dividend,
   input  logic [ALU_W-1:0] divisor,
   output logic [ALU_W-1:0] quotient,
   output logic [ALU_W-1:0] remainder
);

   logic [ALU_W-1:0] rem_s [0:ALU_W];

   assign rem_s[0] = '0;

   for (genvar i = 0; i < ALU_W; i++) begin : g_stage
      logic [ALU_W:0]   shifted;
      logic             ge;
      logic [ALU_W-1:0] diff;

      assign shifted = {rem_s[i], dividend[ALU_W-1-i]};
      // A set MSB means the partial remainder already exceeds any 8-bit divisor;
      // the 8-bit difference is exact because the true result is below the divisor.
      assign ge      = shifted[ALU_W] | (shifted[ALU_W-1:0] >= divisor);
      assign diff    = shifted[ALU_W-1:0] - divisor;

      assign quotient[ALU_W-1-i] = ge;
      assign rem_s[i+1]          = ge ? diff : shifted[ALU_W-1:0];
   end

   assign remainder = rem_s[ALU_W];

endmodule

// File: rtl/alu.sv
// 8-bit ALU: combinational operation units feed a result mux captured in one output register.
// Optional macro ALU_DIV_EN compiles in the divider for DIV/MOD; otherwise those ops return 0.
module alu
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [ALU_W-1:0] A,
   input  logic [ALU_W-1:0] B,
   input  logic [2:0]       Op,
   output logic [ALU_W-1:0] R,
   input  logic             c_in
);

   logic [ALU_W-1:0] b_eff_p0;
   logic [ALU_W-1:0] add_p0;
   logic [ALU_W-1:0] shl_p0;
   logic [ALU_W-1:0] shr_p0;
   logic [ALU_W-1:0] neg_p0;
   logic [ALU_W-1:0] res_p0;
   logic [ALU_W-1:0] r_p1;

   // One adder serves both ADD and SUB; SUB inverts B and relies on c_in for the +1.
   assign b_eff_p0 = (Op == OP_SUB) ? ~B : B;
   assign add_p0   = A + b_eff_p0 + {{(ALU_W-1){1'b0}}, c_in};
   assign shl_p0   = A << B[2:0];
   assign shr_p0   = A >> B[2:0];
   assign neg_p0   = ~A + {{(ALU_W-1){1'b0}}, 1'b1};

`ifdef ALU_DIV_EN
   logic [ALU_W-1:0] quo_p0;
   logic [ALU_W-1:0] rem_p0;

   alu_divider u_divider (
      .dividend  (A),
      .divisor   (B),
      .quotient  (quo_p0),
      .remainder (rem_p0)
   );
`endif

   always_comb begin
      res_p0 = '0;
      case (Op)
         OP_ADD,
         OP_SUB:  res_p0 = add_p0;
         OP_SHL:  res_p0 = shl_p0;
         OP_SHR:  res_p0 = shr_p0;
         OP_NEG:  res_p0 = neg_p0;
`ifdef ALU_DIV_EN
         OP_DIV:  res_p0 = quo_p0;
         OP_MOD:  res_p0 = rem_p0;
`else
         OP_DIV,
         OP_MOD:  res_p0 = '0;
`endif
         OP_PASS: res_p0 = A;
         default: res_p0 = '0;
      endcase
   end

   // p0 -> p1: result register, cleared by reset
   always_ff @(posedge clk) begin
      if (reset) r_p1 <= '0;
      else       r_p1 <= res_p0;
   end

   assign R = r_p1;

endmodule

// File: tb/tb_alu.sv
// Randomised self-checking bench for alu: a behavioural model predicts R one cycle after each
// set of inputs, with literal pins on hand-computed cases. Honours ALU_DIV_EN like the design.
module tb_alu;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] A, B, R;
   logic [2:0] Op;
   logic       c_in;

   int vectors = 0;
   int errors  = 0;

   logic       pend_pin_en = 1'b0;
   logic [7:0] pend_pin    = 8'h00;
   string      pend_name   = "";

   logic       exp_valid  = 1'b0;
   logic [7:0] exp_r      = 8'h00;
   logic       exp_pin_en = 1'b0;
   logic [7:0] exp_pin    = 8'h00;
   string      exp_name   = "";

   alu dut (
      .clk   (clk),
      .reset (reset),
      .A     (A),
      .B     (B),
      .Op    (Op),
      .R     (R),
      .c_in  (c_in)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] model(input int a, input int b, input int op,
                                        input int cin, input bit rst);
      int r;
      if (rst) return 8'h00;
      case (op)
         0: r = a + b + cin;
         1: r = a + (255 - b) + cin;
         2: r = a * (1 << (b % 8));
         3: r = a / (1 << (b % 8));
         4: r = 256 - a;
`ifdef ALU_DIV_EN
         5: r = (b == 0) ? 255 : a / b;
         6: r = (b == 0) ? a : a % b;
`else
         5: r = 0;
         6: r = 0;
`endif
         default: r = a;
      endcase
      return 8'(r % 256);
   endfunction

   // Capture the prediction at the edge the DUT samples its inputs.
   always @(posedge clk) begin
      exp_r      <= model(int'(A), int'(B), int'(Op), int'(c_in), reset);
      exp_valid  <= 1'b1;
      exp_pin_en <= pend_pin_en;
      exp_pin    <= pend_pin;
      exp_name   <= pend_name;
   end

   always @(negedge clk) begin
      if (exp_valid) begin
         vectors++;
         if (R !== exp_r) begin
            errors++;
            $display("FAIL model_check: R=%02h expected %02h", R, exp_r);
         end
         if (exp_pin_en) begin
            vectors++;
            if (R !== exp_pin || exp_r !== exp_pin) begin
               errors++;
               $display("FAIL %s: R=%02h model=%02h required %02h", exp_name, R, exp_r, exp_pin);
            end
         end
      end
   end

   task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic cin, input logic rst,
                        input logic pin_en, input logic [7:0] pin, input string name);
      @(negedge clk);
      A = a; B = b; Op = op; c_in = cin; reset = rst;
      pend_pin_en = pin_en; pend_pin = pin; pend_name = name;
   endtask

   logic [7:0] div_q, div_r, div_q0, div_r0;

   initial begin
      A = 8'h00; B = 8'h00; Op = 3'd0; c_in = 1'b0; reset = 1'b1;
`ifdef ALU_DIV_EN
      div_q = 8'h03; div_r = 8'h02; div_q0 = 8'hFF; div_r0 = 8'h14;
`else
      div_q = 8'h00; div_r = 8'h00; div_q0 = 8'h00; div_r0 = 8'h00;
`endif
      drive(8'h14, 8'h06, 3'd0, 1'b0, 1'b1, 1'b1, 8'h00, "reset_clears");
      drive(8'h14, 8'h06, 3'd0, 1'b0, 1'b0, 1'b1, 8'h1A, "add_after_reset");
      drive(8'h14, 8'h06, 3'd1, 1'b1, 1'b0, 1'b1, 8'h0E, "sub");
      drive(8'h03, 8'h05, 3'd1, 1'b1, 1'b0, 1'b1, 8'hFE, "sub_underflow");
      drive(8'h14, 8'h06, 3'd2, 1'b0, 1'b0, 1'b1, 8'h00, "shl_6");
      drive(8'h14, 8'h06, 3'd3, 1'b0, 1'b0, 1'b1, 8'h00, "shr_6");
      drive(8'h14, 8'h02, 3'd2, 1'b0, 1'b0, 1'b1, 8'h50, "shl_2");
      drive(8'h14, 8'h02, 3'd3, 1'b0, 1'b0, 1'b1, 8'h05, "shr_2");
      drive(8'h14, 8'h02, 3'd4, 1'b1, 1'b0, 1'b1, 8'hEC, "neg");
      drive(8'h14, 8'h02, 3'd7, 1'b1, 1'b0, 1'b1, 8'h14, "pass");
      drive(8'h00, 8'h02, 3'd4, 1'b0, 1'b0, 1'b1, 8'h00, "neg_zero");
      drive(8'h80, 8'h02, 3'd4, 1'b0, 1'b0, 1'b1, 8'h80, "neg_80");
      drive(8'h14, 8'h06, 3'd5, 1'b0, 1'b0, 1'b1, div_q,  "div");
      drive(8'h14, 8'h06, 3'd6, 1'b0, 1'b0, 1'b1, div_r,  "mod");
      drive(8'h14, 8'h00, 3'd5, 1'b0, 1'b0, 1'b1, div_q0, "div_by_zero");
      drive(8'h14, 8'h00, 3'd6, 1'b0, 1'b0, 1'b1, div_r0, "mod_by_zero");
      drive(8'hFF, 8'h01, 3'd0, 1'b1, 1'b0, 1'b1, 8'h01, "add_wrap");
      for (int i = 0; i < 7; i++)
         drive(8'h14, 8'h06, 3'(i), 1'b0, 1'b0, 1'b0, 8'h00, "");
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] rb;
         rb = 8'($urandom);
         if ($urandom_range(0, 7) == 0) rb = 8'h00;
         drive(8'($urandom), rb, 3'($urandom), 1'($urandom),
               ($urandom_range(0, 49) == 0), 1'b0, 8'h00, "");
      end
      drive(8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, "");
      @(negedge clk);
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/alu.md
# alu

8-bit registered arithmetic/logic unit selecting one of eight operations on operands `A` and `B` via a 3-bit opcode. Serves as the datapath execution block: combinational operation units (adder, shifter, complementer, divider) feed a result mux whose output is captured in a single output register. One clock, synchronous active-high reset.

## Interface
- Parameters: none (width fixed at 8 bits).
- `clk` input 1: rising-edge clock. One clock; reset is synchronous and active-high.
- `reset` input 1: synchronous, active-high; clears `R`.
- `A` input 8: operand A, unsigned.
- `B` input 8: operand B, unsigned; `B[2:0]` is the shift amount for shift ops.
- `Op` input 3: operation select.
- `R` output 8: registered result.
- `c_in` input 1: carry-in for ADD/SUB.
- Positional order for instantiation (clock/reset excluded): `A, B, Op, R, c_in`.

## Operation
- Op 0 ADD: `R = (A + B + c_in) mod 256`.
- Op 1 SUB: `R = (A + ~B + c_in) mod 256`; with `c_in=1` this is `A - B` (two's complement wrap on underflow).
- Op 2 SHL: `R = A << B[2:0]`, zero fill, bits shifted out discarded; `B[7:3]` ignored.
- Op 3 SHR: `R = A >> B[2:0]`, logical, zero fill.
- Op 4 NEG: `R = (~A + 1) mod 256`; `A=0 -> 0`, `A=0x80 -> 0x80`.
- Op 5 DIV: `R = A / B` unsigned quotient, truncated.
- Op 6 MOD: `R = A % B` unsigned remainder.
- Op 7 PASS: `R = A`.
- Divide by zero (`B=0`): Op 5 gives `0xFF`, Op 6 gives `A`.
- `c_in` ignored for Ops 2–7.
- No carry-out, overflow or status flags.

## Timing
- All operation units are combinational; the result mux output is registered on the rising edge of `clk`.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on `R` after edge N.
- Throughput: one operation per cycle; `Op` may change every cycle with no hazards.
- `reset=1` at an edge: `R <= 0x00`, overriding any operation; normal operation resumes at the first edge with `reset=0`.
- Reset value of `R`: `0x00`.

## Configuration
- Macro `ALU_DIV_EN`:
  - Defined: divider compiled in; Ops 5/6 behave as specified.
  - Not defined: divider omitted; Ops 5/6 yield `R = 0x00`.
  - All other opcodes are identical in both builds.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants `OP_ADD=0`, `OP_SUB=1`, `OP_SHL=2`, `OP_SHR=3`, `OP_NEG=4`, `OP_DIV=5`, `OP_MOD=6`, `OP_PASS=7`.
  - Width constant `ALU_W=8`.
- Sub-module `alu_divider`: combinational 8-stage restoring divider producing quotient and remainder, instantiated only under `ALU_DIV_EN`.
- Adder, shifter and complementer are inline logic in `alu`.

## Test plan
- Reset: assert `reset` for 1 cycle with `A=0x14`, `Op=0` -> `R=0x00`; deassert -> next edge `R=0x14+B`.
- `A=0x14`, `B=0x06`, `c_in=0`, Op 0 -> `0x1A`; Op 1 with `c_in=1` -> `0x0E`; `A=0x03`, `B=0x05`, Op 1, `c_in=1` -> `0xFE`.
- `A=0x14`, `B=0x06`: Op 2 -> `0x00`, Op 3 -> `0x00`; `B=0x02`: Op 2 -> `0x50`, Op 3 -> `0x05`.
- `A=0x14`: Op 4 -> `0xEC`; Op 7 -> `0x14`; `A=0x00`, Op 4 -> `0x00`.
- Division with `ALU_DIV_EN` defined:
  - `A=0x14`, `B=0x06`: Op 5 -> `0x03`, Op 6 -> `0x02`.
  - `B=0`: Op 5 -> `0xFF`, Op 6 -> `0x14`.
  - Without the macro: Op 5 and Op 6 -> `0x00`.
- Back-to-back: change `Op` 0..6 on consecutive edges -> each result appears exactly one cycle after its opcode.
